spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spimaster

---
 rtl/spi_master.sv | 203 ++++++++++++++++++++
 tb/tb_spi_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Single-slave SPI master.
// - SCK idles high.
// - The slave select is active low.
// - MOSI changes on rising SCK edges.
// - MISO is sampled on the clk edge that drives SCK low.
// - Data is transferred MSB first.
// - Every output is a flop, so nothing glitches on state changes.
//
// Timing for a transaction accepted at edge T0 (D = CLK_DIV, W = DATA_WIDTH):
//   falling SCK edge k (k = 1..W) : T0 + D*(2k-1)
//   rising  SCK edge k            : T0 + D*2k
//   ss high, data_o load, done    : T0 + D*(2W+1)
//   busy low, back to IDLE        : T0 + D*(2W+2)
//
// Parameters
//   DATA_WIDTH : bits per transaction (2 or more)
//   CLK_DIV    : clk cycles per SCK half-period (1..255)
//
// Ports
//   clk    : system clock; all state changes on its rising edge
//   rst    : asynchronous, active-high reset; aborts any transfer
//   start  : transaction request, only looked at while idle
//   data_i : word to send, captured when start is accepted
//   data_o : last completely received word
//   busy   : high whenever a start request would be ignored
//   done   : one-clk pulse when a transfer completes
//   sck    : SPI clock (idles high)
//   sdo    : MOSI
//   sdi    : MISO, assumed synchronous to clk
//   ss     : slave select, active low
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  ss
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [7:0]       RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  // SETUP  : ss low, first bit on sdo, sck still high
  // SCK_LO : sck low half-period (sdi already sampled on entry)
  // SCK_HI : sck high half-period between bits
  // HOLD   : sck high after the last bit, ss still low
  // GAP    : ss high, still busy, so back-to-back frames keep a gap
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD,
    GAP
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] data_o_nxt;
  logic                  busy_nxt, done_nxt, sck_nxt, sdo_nxt, ss_nxt;
  logic                  tick;

  // The half-period counter expires when it reaches zero.
  // IDLE never waits on it.
  assign tick = (cnt == 8'd0);

  // Next-state and next-output logic.
  // Every output is computed here one cycle ahead, then registered.
  //
  // A single shift register carries both directions:
  // - transmit bits leave from the MSB end;
  // - received bits enter at the LSB end.
  // After DATA_WIDTH falling edges it holds exactly the received word.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    data_o_nxt  = data_o;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sck_nxt     = sck;
    sdo_nxt     = sdo;
    ss_nxt      = ss;

    if (state != IDLE && !tick) begin
      cnt_nxt = cnt - 8'd1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SETUP;
          cnt_nxt     = RELOAD;
          shreg_nxt   = data_i;
          bit_cnt_nxt = '0;
          ss_nxt      = 1'b0;
          sdo_nxt     = data_i[DATA_WIDTH-1];
          busy_nxt    = 1'b1;
        end
      end

      // Both of these end with a falling SCK edge.
      // The slave has had a full half-period to settle sdi, so sample it now.
      SETUP, SCK_HI: begin
        if (tick) begin
          state_nxt   = SCK_LO;
          cnt_nxt     = RELOAD;
          sck_nxt     = 1'b0;
          shreg_nxt   = {shreg[DATA_WIDTH-2:0], sdi};
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end

      // Rising edge.
      // Present the next bit unless the word is finished.
      // After the last bit, sdo keeps the LSB and the FSM parks in HOLD.
      SCK_LO: begin
        if (tick) begin
          cnt_nxt = RELOAD;
          sck_nxt = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = SCK_HI;
            sdo_nxt   = shreg[DATA_WIDTH-1];
          end
        end
      end

      HOLD: begin
        if (tick) begin
          state_nxt  = GAP;
          cnt_nxt    = RELOAD;
          ss_nxt     = 1'b1;
          data_o_nxt = shreg;
          done_nxt   = 1'b1;
        end
      end

      GAP: begin
        if (tick) begin
          state_nxt = IDLE;
          cnt_nxt   = RELOAD;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
        sck_nxt   = 1'b1;
        ss_nxt    = 1'b1;
      end
    endcase
  end

  // State and output registers.
  // Reset forces the bus idle straight away, so a transfer in flight is
  // dropped without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_o  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b1;
      sdo     <= 1'b0;
      ss      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      data_o  <= data_o_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sck     <= sck_nxt;
      sdo     <= sdo_nxt;
      ss      <= ss_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Two masters share one clock and reset:
//   unit 0 : DATA_WIDTH=8, CLK_DIV=4
//   unit 1 : DATA_WIDTH=8, CLK_DIV=1
//
// Each unit's sdi comes either from its own sdo (loopback) or from a small
// SPI slave model. The slave shifts out on rising SCK and captures on
// falling SCK.
//
// Expected waveforms are worked out per cycle from the SCK timing formulas,
// counted from the accepting edge T0.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int W  = 8;
  localparam int D0 = 4;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]   start_v;
  logic [1:0]   loop_v;
  logic [W-1:0] data_i_v   [2];
  logic [W-1:0] slave_tx_v [2];
  wire  [1:0]   busy_w, done_w, sck_w, sdo_w, ss_w, sdi_w;
  wire  [W-1:0] dout0, dout1;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] model_dout [2];

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(D0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_i(data_i_v[0]),
    .data_o(dout0), .busy(busy_w[0]), .done(done_w[0]), .sck(sck_w[0]),
    .sdo(sdo_w[0]), .sdi(sdi_w[0]), .ss(ss_w[0])
  );

  spi_master #(.DATA_WIDTH(W), .CLK_DIV(D1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_i(data_i_v[1]),
    .data_o(dout1), .busy(busy_w[1]), .done(done_w[1]), .sck(sck_w[1]),
    .sdo(sdo_w[1]), .sdi(sdi_w[1]), .ss(ss_w[1])
  );

  // Per-unit slave model and falling-edge counter
  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic [W-1:0] tx_sh = '0;
    logic [W-1:0] rx_sh = '0;
    int fall_cnt = 0;

    assign sdi_w[g] = loop_v[g] ? sdo_w[g] : tx_sh[W-1];

    always begin
      @(negedge ss_w[g]);
      tx_sh = slave_tx_v[g];
      while (ss_w[g] === 1'b0) begin
        @(posedge sck_w[g] or posedge ss_w[g]);
        if (ss_w[g] === 1'b0) tx_sh = {tx_sh[W-2:0], 1'b0};
      end
    end

    always @(negedge sck_w[g]) begin
      fall_cnt++;
      if (ss_w[g] === 1'b0) rx_sh = {rx_sh[W-2:0], sdo_w[g]};
    end
  end

  function automatic int divOf(input int u);
    return (u != 0) ? D1 : D0;
  endfunction

  function automatic logic [W-1:0] doutOf(input int u);
    return (u != 0) ? dout1 : dout0;
  endfunction

  function automatic int fallCount(input int u);
    return (u != 0) ? g_unit[1].fall_cnt : g_unit[0].fall_cnt;
  endfunction

  function automatic logic [W-1:0] slaveRx(input int u);
    return (u != 0) ? g_unit[1].rx_sh : g_unit[0].rx_sh;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output bundle of one unit, packed as {ss, sck, busy, done, sdo, data_o}
  function automatic logic [31:0] actualOf(input int u);
    return {19'b0, ss_w[u], sck_w[u], busy_w[u], done_w[u], sdo_w[u], doutOf(u)};
  endfunction

  // Expected outputs n cycles after the accepting edge
  task automatic checkOutput(input int u, input int n, input logic [W-1:0] tx,
                             input logic [W-1:0] old_d, input logic [W-1:0] new_d);
    int d;
    int idx;
    logic e_ss, e_sck, e_busy, e_done, e_sdo;
    logic [W-1:0] e_d;
    d      = divOf(u);
    e_ss   = (n >= (2*W+1)*d);
    e_busy = (n < (2*W+2)*d);
    e_done = (n == (2*W+1)*d);
    e_sck  = !(n >= d && n < 2*W*d && ((n / d) % 2 == 1));
    idx    = n / (2*d);
    if (idx > W-1) idx = W-1;
    e_sdo  = tx[W-1-idx];
    e_d    = e_ss ? new_d : old_d;
    compare($sformatf("u%0d tx=%h cycle T0+%0d {ss,sck,busy,done,sdo,data_o}", u, tx, n),
            actualOf(u), {19'b0, e_ss, e_sck, e_busy, e_done, e_sdo, e_d});
  endtask

  // One complete transaction.
  // hold  : keep start high during the transfer (otherwise start is random).
  // chain : leave start high at the end, so the next transfer begins on the
  //         first IDLE edge.
  // data_i is scrambled every cycle to show it is captured only at T0.
  task automatic applyStimulus(input int u, input logic [W-1:0] tx, input bit lp,
                               input logic [W-1:0] slave, input bit hold, input bit chain,
                               input logic [W-1:0] exp_rx);
    int d, len, f0;
    logic [W-1:0] old_d;
    d     = divOf(u);
    len   = (2*W+2)*d;
    old_d = model_dout[u];
    f0    = fallCount(u);
    loop_v[u]     = lp;
    slave_tx_v[u] = slave;
    data_i_v[u]   = tx;
    start_v[u]    = 1'b1;
    for (int n = 0; n <= len; n++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput(u, n, tx, old_d, exp_rx);
      data_i_v[u] = W'($urandom);
      if (n < len) start_v[u] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      else         start_v[u] = chain;
    end
    model_dout[u] = exp_rx;
    compare($sformatf("u%0d tx=%h falling sck count", u, tx), 32'(fallCount(u) - f0), 32'(W));
    if (!lp) compare($sformatf("u%0d tx=%h slave captured", u, tx), 32'(slaveRx(u)), 32'(tx));
  endtask

  typedef struct {
    int           unit;
    logic [W-1:0] tx;
    bit           lp;
    logic [W-1:0] slave;
    bit           hold;
    bit           chain;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int f0;
    vecs[0] = '{0, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{0, 8'h80, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{0, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 8'h01};
    vecs[3] = '{0, 8'hFE, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFE};
    vecs[4] = '{1, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC3};
    vecs[5] = '{1, 8'h80, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[6] = '{1, 8'h55, 1'b0, 8'h99, 1'b1, 1'b1, 8'h99};
    vecs[7] = '{1, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, 8'hAA};

    rst           = 1'b1;
    start_v       = 2'b00;
    loop_v        = 2'b11;
    data_i_v[0]   = '0;
    data_i_v[1]   = '0;
    slave_tx_v[0] = '0;
    slave_tx_v[1] = '0;
    model_dout[0] = '0;
    model_dout[1] = '0;

    // Reset values of both units
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      compare($sformatf("u%0d reset outputs", u), actualOf(u), {19'b0, 5'b11000, 8'h00});
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].unit, vecs[i].tx, vecs[i].lp, vecs[i].slave,
                    vecs[i].hold, vecs[i].chain, vecs[i].exp_rx);

    // Reset after the third falling SCK edge of a unit-0 transfer
    f0          = fallCount(0);
    loop_v[0]   = 1'b1;
    data_i_v[0] = 8'h96;
    start_v[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5*D0) begin
      @(posedge clk);
      @(negedge clk);
    end
    compare("abort: falling edges before reset", 32'(fallCount(0) - f0), 32'd3);
    rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++)
      compare($sformatf("u%0d outputs right after reset", u), actualOf(u),
              {19'b0, 5'b11000, 8'h00});
    model_dout[0] = '0;
    model_dout[1] = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      compare("u0 outputs during reset", actualOf(0), {19'b0, 5'b11000, 8'h00});
    end
    rst = 1'b0;
    applyStimulus(0, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A);

    // Randomized transfers
    for (int i = 0; i < 8; i++) begin
      int u;
      logic [W-1:0] tx, sl;
      bit lp;
      u  = $urandom_range(0, 1);
      tx = W'($urandom);
      sl = W'($urandom);
      lp = 1'($urandom_range(0, 1));
      applyStimulus(u, tx, lp, sl, 1'b0, 1'b0, lp ? tx : sl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
